// File: rtl/regfile_pkg.sv
// Shared register-file widths and the address/data types used by decode and execute.
package regfile_pkg;

  localparam int unsigned RF_DATA_W = 32;
  localparam int unsigned RF_ADDR_W = 5;
  localparam int unsigned RF_N_RD   = 2;
  localparam int unsigned RF_DEPTH  = 1 << RF_ADDR_W;

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;
  typedef logic [RF_DATA_W-1:0] rf_data_t;

  // Write request as carried from writeback to the register file.
  typedef struct packed {
    logic     we;
    rf_addr_t addr;
    rf_data_t data;
  } rf_wr_t;

  // Register 0 is the architectural zero register.
  function automatic logic rf_is_zero_addr(input rf_addr_t addr);
    return addr == '0;
  endfunction

endpackage

// File: rtl/rf_read_mux.sv
// DEPTH:1 word selector, purely combinational, defined for every selector value.
module rf_read_mux #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic [ADDR_W-1:0]                  sel,
  input  logic [(DATA_W << ADDR_W)-1:0]      words,
  output logic [DATA_W-1:0]                  dout_c
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  // Default to zero, then pick the addressed word; no latch, no X selector.
  always_comb begin
    dout_c = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (sel == ADDR_W'(i)) begin
        dout_c = words[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/regfile_mport.sv
// Multi-port register file: N_RD registered read ports, one write port,
// write-to-read bypass and optional hardwired zero register.
module regfile_mport
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W  = RF_DATA_W,
  parameter int unsigned ADDR_W  = RF_ADDR_W,
  parameter int unsigned N_RD    = RF_N_RD,
  parameter int unsigned ZERO_R0 = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     we_i,
  input  logic [ADDR_W-1:0]        waddr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic [N_RD-1:0]          re_i,
  input  logic [N_RD*ADDR_W-1:0]   raddr_i,
  output logic [N_RD*DATA_W-1:0]   rdata_o,
  output logic [N_RD-1:0]          rvalid_o
);

  localparam int unsigned DEPTH   = 1 << ADDR_W;
  localparam bit          ZERO_EN = (ZERO_R0 != 0);

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [DEPTH*DATA_W-1:0]      mem_flat;
  logic                         wr_ok_c;

  assign mem_flat = mem;

  // Writes to r0 are dropped when it is the hardwired zero register.
  always_comb begin
    wr_ok_c = we_i;
    if (ZERO_EN && (waddr_i == '0)) begin
      wr_ok_c = 1'b0;
    end
  end

  // Storage flops; reset clears every entry, so this cannot map to a RAM macro.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem <= '0;
    end else if (wr_ok_c) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  for (genvar k = 0; k < N_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] mem_word_c;
    logic [DATA_W-1:0] sel_word_c;
    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q;

    assign raddr = raddr_i[k*ADDR_W +: ADDR_W];

    rf_read_mux #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_mux (
      .sel    (raddr),
      .words  (mem_flat),
      .dout_c (mem_word_c)
    );

    // Zero register beats bypass, bypass beats stored contents.
    always_comb begin
      sel_word_c = mem_word_c;
      if (ZERO_EN && (raddr == '0)) begin
        sel_word_c = '0;
      end else if (we_i && (waddr_i == raddr)) begin
        sel_word_c = wdata_i;
      end
    end

    // Output register: capture on enable, hold data and drop valid when idle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rvalid_q <= re_i[k];
        if (re_i[k]) begin
          rdata_q <= sel_word_c;
        end
      end
    end

    assign rdata_o[k*DATA_W +: DATA_W] = rdata_q;
    assign rvalid_o[k]                 = rvalid_q;
  end

endmodule

// File: tb/tb_regfile_mport.sv
// Directed, table-driven bench for regfile_mport with default parameters.
module tb_regfile_mport;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 2;

  logic             clk;
  logic             rst_n;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [DW-1:0]    wdata;
  logic [NR-1:0]    re;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0]    rvalid;

  int n_chk;
  int n_pass;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [1:0]  re;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [1:0]  ev;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;

  vec_t vt[10];

  regfile_mport dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .we_i     (we),
    .waddr_i  (waddr),
    .wdata_i  (wdata),
    .re_i     (re),
    .raddr_i  (raddr),
    .rdata_o  (rdata),
    .rvalid_o (rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [1:0] r, input logic [4:0] a0, input logic [4:0] a1);
    we    = w;
    waddr = wa;
    wdata = wd;
    re    = r;
    raddr = {a1, a0};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] fill_val(input int i);
    return (i == 0) ? 32'h0 : 32'(i) * 32'h01010101;
  endfunction

  initial begin
    n_chk  = 0;
    n_pass = 0;

    vt[0] = '{1'b1, 5'd7, 32'h12345678, 2'b00, 5'd0, 5'd0, 2'b00, 32'h0,        32'h0};
    vt[1] = '{1'b0, 5'd0, 32'h0,        2'b01, 5'd7, 5'd0, 2'b01, 32'h12345678, 32'h0};
    vt[2] = '{1'b1, 5'd3, 32'h1,        2'b00, 5'd0, 5'd0, 2'b00, 32'h12345678, 32'h0};
    vt[3] = '{1'b1, 5'd3, 32'hA5A5A5A5, 2'b11, 5'd3, 5'd3, 2'b11, 32'hA5A5A5A5, 32'hA5A5A5A5};
    vt[4] = '{1'b0, 5'd0, 32'h0,        2'b11, 5'd7, 5'd3, 2'b11, 32'h12345678, 32'hA5A5A5A5};
    vt[5] = '{1'b1, 5'd0, 32'hFFFFFFFF, 2'b00, 5'd0, 5'd0, 2'b00, 32'h12345678, 32'hA5A5A5A5};
    vt[6] = '{1'b1, 5'd0, 32'hFFFFFFFF, 2'b11, 5'd0, 5'd0, 2'b11, 32'h0,        32'h0};
    vt[7] = '{1'b1, 5'd9, 32'hCAFEF00D, 2'b10, 5'd7, 5'd9, 2'b10, 32'h0,        32'hCAFEF00D};
    vt[8] = '{1'b0, 5'd0, 32'h0,        2'b01, 5'd9, 5'd7, 2'b01, 32'hCAFEF00D, 32'hCAFEF00D};
    vt[9] = '{1'b0, 5'd0, 32'h0,        2'b10, 5'd0, 5'd7, 2'b10, 32'hCAFEF00D, 32'h12345678};

    // Power-on reset
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0);
    #12;
    check("por_rvalid", 32'(rvalid), 32'h0);
    check("por_rdata0", rdata[31:0], 32'h0);
    check("por_rdata1", rdata[63:32], 32'h0);
    rst_n = 1'b1;

    // Write r5, read it back, then pulse reset between edges
    drive(1'b1, 5'd5, 32'hDEADBEEF, 2'b00, 5'd0, 5'd0);
    step();
    drive(1'b0, 5'd0, 32'h0, 2'b01, 5'd5, 5'd0);
    step();
    check("r5_before_rst", rdata[31:0], 32'hDEADBEEF);
    check("r5_valid_before_rst", 32'(rvalid), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_pulse_rvalid", 32'(rvalid), 32'h0);
    check("rst_pulse_rdata0", rdata[31:0], 32'h0);
    #1 rst_n = 1'b1;
    step();
    check("r5_after_rst", rdata[31:0], 32'h0);
    check("r5_after_rst_valid", 32'(rvalid), 32'h1);

    // Directed vector table
    for (int i = 0; i < 10; i++) begin
      drive(vt[i].we, vt[i].wa, vt[i].wd, vt[i].re, vt[i].a0, vt[i].a1);
      step();
      check($sformatf("vec%0d_rvalid", i), 32'(rvalid), 32'(vt[i].ev));
      check($sformatf("vec%0d_rdata0", i), rdata[31:0], vt[i].e0);
      check($sformatf("vec%0d_rdata1", i), rdata[63:32], vt[i].e1);
    end

    // Fill every register with i*0x01010101 (r0 stays zero)
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 5'(i), 32'(i) * 32'h01010101, 2'b00, 5'd0, 5'd0);
      step();
    end

    // Opposing sweeps at full throughput, port 1 paused for one cycle mid-sweep
    for (int c = 0; c < 32; c++) begin
      drive(1'b0, 5'd0, 32'h0, (c == 16) ? 2'b01 : 2'b11, 5'(c), 5'(31 - c));
      step();
      check($sformatf("sweep%0d_rvalid", c), 32'(rvalid), (c == 16) ? 32'h1 : 32'h3);
      check($sformatf("sweep%0d_rdata0", c), rdata[31:0], fill_val(c));
      check($sformatf("sweep%0d_rdata1", c), rdata[63:32],
            (c == 16) ? fill_val(16) : fill_val(31 - c));
    end

    drive(1'b0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0);
    step();
    check("idle_rvalid", 32'(rvalid), 32'h0);
    check("idle_hold_rdata0", rdata[31:0], fill_val(31));
    check("idle_hold_rdata1", rdata[63:32], fill_val(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
